// File: rtl/jedro_1_dram_resp.sv
// Data-memory responder for the jedro_1 dram port: word RAM with byte enables, programmable wait states, err on bad access.
// Optional macro JEDRO_1_DRAM_RESP_ALIGN_CHK_EN adds misalignment and byte-enable pattern checks.
//
// state  | meaning
// IDLE   | waiting for stb; a request is captured on the edge it is seen
// WAIT   | counting down wait states before the response cycle
// RESP   | decode captured request, access RAM, raise ack or err on the next edge

module jedro_1_dram_resp #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  stb,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ack,
    output logic                  err
);

    localparam int                    IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(DEPTH_WORDS * 4);
    localparam logic [3:0]            WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [3:0]            we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [DATA_WIDTH-1:0] ram [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic                  pattern_ok;
    logic                  req_ok;
    logic                  ram_we;

    // Subtraction is only meaningful when addr_q >= BASE_ADDR, so both bounds are checked explicitly.
    assign offset   = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && (offset < SPAN);
    assign idx      = offset[IDX_W+1:2];

`ifdef JEDRO_1_DRAM_RESP_ALIGN_CHK_EN
    logic legal_we;
    logic misaligned;

    always_comb begin
        legal_we = 1'b0;
        case (we_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: legal_we = 1'b1;
            default:                            legal_we = 1'b0;
        endcase
        misaligned = (addr_q[1:0] != 2'b00) && ((we_q == 4'b0000) || (we_q == 4'b1111));
        pattern_ok = legal_we && !misaligned;
    end
`else
    assign pattern_ok = 1'b1;
`endif

    assign req_ok = in_range && pattern_ok;
    assign ram_we = (state == S_RESP) && req_ok && (we_q != 4'b0000);

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int k = 0; k < 4; k++) begin
                if (we_q[k]) begin
                    ram[idx][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            we_q    <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (stb) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (WAIT_STATES == 0) begin
                            state <= S_RESP;
                        end else begin
                            cnt   <= WAIT_LOAD;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (req_ok) begin
                        if (we_q == 4'b0000) begin
                            rdata <= ram[idx];
                        end
                        ack <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jedro_1_dram_resp.sv
// Directed bench for jedro_1_dram_resp: one instance with no wait states, one with three.
// Expected values are hand-computed; latency counted in clocks from the stb drive.

module tb_jedro_1_dram_resp;

    logic        clk_sys = 1'b0;
    logic        rst_b;

    logic        stb_a, stb_b;
    logic [3:0]  we_a, we_b;
    logic [31:0] addr_a, addr_b;
    logic [31:0] wdata_a, wdata_b;
    logic [31:0] rdata_a, rdata_b;
    logic        ack_a, ack_b, err_a, err_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    jedro_1_dram_resp #(.WAIT_STATES(0)) u_dut_a (
        .clk_i (clk_sys), .rstn_i(rst_b), .stb(stb_a), .we(we_a), .addr(addr_a),
        .wdata (wdata_a), .rdata(rdata_a), .ack(ack_a), .err(err_a)
    );

    jedro_1_dram_resp #(.WAIT_STATES(3)) u_dut_b (
        .clk_i (clk_sys), .rstn_i(rst_b), .stb(stb_b), .we(we_b), .addr(addr_b),
        .wdata (wdata_b), .rdata(rdata_b), .ack(ack_b), .err(err_b)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            stb_a = s; we_a = w; addr_a = a; wdata_a = d;
        end else begin
            stb_b = s; we_b = w; addr_b = a; wdata_b = d;
        end
    endtask

    task automatic drop_stb(input int sel);
        if (sel == 0) stb_a = 1'b0;
        else          stb_b = 1'b0;
    endtask

    task automatic sample(input int sel, output logic a, output logic e, output logic [31:0] r);
        if (sel == 0) begin
            a = ack_a; e = err_a; r = rdata_a;
        end else begin
            a = ack_b; e = err_b; r = rdata_b;
        end
    endtask

    // One request; checks latency, response kind, exclusivity and one-cycle pulse width.
    task automatic xfer(input string tag, input int sel, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_ack, input int exp_lat, output logic [31:0] rd);
        logic        got_a, got_e, sa, se;
        logic [31:0] sr;
        int          lat;
        got_a = 1'b0; got_e = 1'b0; rd = '0; lat = -1;
        @(negedge clk_sys);
        drive(sel, 1'b1, w, a, d);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk_sys);
            if (c == 1) drop_stb(sel);
            sample(sel, sa, se, sr);
            if (sa || se) begin
                got_a = sa; got_e = se; rd = sr; lat = c;
                break;
            end
        end
        chk_eq({tag, "_lat"}, lat, exp_lat);
        chk_eq({tag, "_ack"}, {31'd0, got_a}, {31'd0, exp_ack});
        chk_eq({tag, "_err"}, {31'd0, got_e}, {31'd0, ~exp_ack});
        @(negedge clk_sys);
        sample(sel, sa, se, sr);
        chk_eq({tag, "_pulse"}, {30'd0, sa, se}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          n_resp, first;

        rst_b = 1'b0;
        drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk_sys);
        chk_eq("rst_ack_a", {31'd0, ack_a}, 32'd0);
        chk_eq("rst_err_a", {31'd0, err_a}, 32'd0);
        chk_eq("rst_rdata_a", rdata_a, 32'd0);
        chk_eq("rst_rdata_b", rdata_b, 32'd0);
        rst_b = 1'b1;
        @(negedge clk_sys);

        // Zero wait states: full write, read back, partial write merge.
        xfer("wr10", 0, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b1, 2, rd);
        xfer("rd10", 0, 4'b0000, 32'h10, 32'h0, 1'b1, 2, rd);
        chk_eq("rd10_data", rd, 32'hDEADBEEF);
        xfer("pw10", 0, 4'b0100, 32'h10, 32'h00AA0000, 1'b1, 2, rd);
        chk_eq("pw_keeps_rdata", rdata_a, 32'hDEADBEEF);
        xfer("rd10b", 0, 4'b0000, 32'h10, 32'h0, 1'b1, 2, rd);
        chk_eq("rd10b_data", rd, 32'hDEAABEEF);

        // Out of range, and the last in-range word.
        xfer("wr0", 0, 4'b1111, 32'h0, 32'h11111111, 1'b1, 2, rd);
        xfer("rd1000", 0, 4'b0000, 32'h1000, 32'h0, 1'b0, 2, rd);
        chk_eq("rd1000_rdata", rdata_a, 32'hDEAABEEF);
        xfer("wr1000", 0, 4'b1111, 32'h1000, 32'hFFFFFFFF, 1'b0, 2, rd);
        xfer("rd0", 0, 4'b0000, 32'h0, 32'h0, 1'b1, 2, rd);
        chk_eq("rd0_data", rd, 32'h11111111);
        xfer("wrffc", 0, 4'b1111, 32'hFFC, 32'h0BADCAFE, 1'b1, 2, rd);
        xfer("rdffc", 0, 4'b0000, 32'hFFC, 32'h0, 1'b1, 2, rd);
        chk_eq("rdffc_data", rd, 32'h0BADCAFE);

        // Misaligned full-word write and an odd byte-enable pattern.
        xfer("wr30z", 0, 4'b1111, 32'h30, 32'h0, 1'b1, 2, rd);
`ifdef JEDRO_1_DRAM_RESP_ALIGN_CHK_EN
        xfer("wr11", 0, 4'b1111, 32'h11, 32'hCAFEF00D, 1'b0, 2, rd);
        xfer("rd10c", 0, 4'b0000, 32'h10, 32'h0, 1'b1, 2, rd);
        chk_eq("rd10c_data", rd, 32'hDEAABEEF);
        xfer("wr30p", 0, 4'b0101, 32'h30, 32'hAABBCCDD, 1'b0, 2, rd);
        xfer("rd30", 0, 4'b0000, 32'h30, 32'h0, 1'b1, 2, rd);
        chk_eq("rd30_data", rd, 32'h00000000);
`else
        xfer("wr11", 0, 4'b1111, 32'h11, 32'hCAFEF00D, 1'b1, 2, rd);
        xfer("rd10c", 0, 4'b0000, 32'h10, 32'h0, 1'b1, 2, rd);
        chk_eq("rd10c_data", rd, 32'hCAFEF00D);
        xfer("wr30p", 0, 4'b0101, 32'h30, 32'hAABBCCDD, 1'b1, 2, rd);
        xfer("rd30", 0, 4'b0000, 32'h30, 32'h0, 1'b1, 2, rd);
        chk_eq("rd30_data", rd, 32'h00BB00DD);
`endif

        // Three wait states.
        xfer("b_wr10", 1, 4'b1111, 32'h10, 32'h55AA55AA, 1'b1, 5, rd);
        xfer("b_wr20z", 1, 4'b1111, 32'h20, 32'h0, 1'b1, 5, rd);
        xfer("b_rd10", 1, 4'b0000, 32'h10, 32'h0, 1'b1, 5, rd);
        chk_eq("b_rd10_data", rd, 32'h55AA55AA);

        // A second stb during WAIT must be ignored entirely.
        n_resp = 0; first = -1;
        @(negedge clk_sys);
        drive(1, 1'b1, 4'b0000, 32'h10, 32'h0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_sys);
            if (c == 1) drop_stb(1);
            if (c == 2) drive(1, 1'b1, 4'b1111, 32'h20, 32'hBAD0BAD0);
            if (c == 3) drop_stb(1);
            if (ack_b || err_b) begin
                n_resp++;
                if (first < 0) first = c;
            end
        end
        chk_eq("b_dbl_count", n_resp, 1);
        chk_eq("b_dbl_lat", first, 5);
        xfer("b_rd20", 1, 4'b0000, 32'h20, 32'h0, 1'b1, 5, rd);
        chk_eq("b_rd20_data", rd, 32'h00000000);

        // Reset during WAIT abandons the write.
        @(negedge clk_sys);
        drive(1, 1'b1, 4'b1111, 32'h20, 32'h12345678);
        @(negedge clk_sys);
        drop_stb(1);
        @(negedge clk_sys);
        rst_b = 1'b0;
        #1;
        chk_eq("b_rst_ack", {31'd0, ack_b}, 32'd0);
        chk_eq("b_rst_err", {31'd0, err_b}, 32'd0);
        chk_eq("b_rst_rdata", rdata_b, 32'd0);
        @(negedge clk_sys);
        rst_b = 1'b1;
        n_resp = 0;
        repeat (10) begin
            @(negedge clk_sys);
            if (ack_b || err_b) n_resp++;
        end
        chk_eq("b_rst_noresp", n_resp, 0);
        xfer("b_rd20r", 1, 4'b0000, 32'h20, 32'h0, 1'b1, 5, rd);
        chk_eq("b_rd20r_data", rd, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/jedro_1_dram_resp.md
Name: jedro_1_dram_resp

Overview:
Data-memory responder for the jedro_1 core's dram port. It is the slave end of the core's load/store bus (stb/we/addr/wdata → rdata/ack/err). It holds a synchronous word-organised RAM with byte-write enables and inserts a programmable number of wait states. It flags out-of-range accesses with err. It replaces bytewrite_ram_wrap in core benches where wait-state and error paths need exercising.

Parameters:
- DATA_WIDTH, 32: bus data width. Fixed at 32; byte lanes = DATA_WIDTH/8 = 4.
- ADDR_WIDTH, 32: bus byte-address width.
- DEPTH_WORDS, 1024: RAM depth in 32-bit words (power of 2).
- BASE_ADDR, 32'h0000_0000: byte address of word 0 (DEPTH_WORDS*4-aligned).
- WAIT_STATES, 0: extra cycles between request capture and response (0..15).

Ports:
- clk_i, input, 1: clock, rising edge.
- rstn_i, input, 1: reset, asynchronous, active-low.
- stb, input, 1: request strobe, one-cycle pulse per request.
- we, input, 4: byte write enables. 4'b0000 = read; any nonzero value = write of the enabled lanes.
- addr, input, ADDR_WIDTH: byte address.
- wdata, input, DATA_WIDTH: write data. Lane k = bits 8k+7:8k.
- rdata, output, DATA_WIDTH: read data, valid in the ack cycle.
- ack, output, 1: one-cycle success response.
- err, output, 1: one-cycle error response.

Behaviour:
- Reset (async assert, sync release): ack=0, err=0, rdata=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE with stb=1:
  - Capture we, addr and wdata into request registers.
  - Go to RESP if WAIT_STATES==0; otherwise load the counter with WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, go to RESP.
- RESP (one cycle):
  - Decode: idx = (addr_q-BASE_ADDR)>>2. In range iff BASE_ADDR <= addr_q < BASE_ADDR+4*DEPTH_WORDS.
  - In range: write the enabled lanes of wdata_q into RAM[idx], or for a read load rdata with RAM[idx]. Assert ack on the next edge.
  - Out of range: no RAM update, rdata unchanged, assert err on the next edge.
  - Then return to IDLE.
- Latency: stb at edge N → ack/err high for exactly the cycle after edge N+2+WAIT_STATES. The earliest new stb is accepted in the ack/err cycle, because the FSM is already IDLE then.
- ack and err are never high together. Exactly one of them is asserted per accepted request.
- stb while in WAIT or RESP is ignored: no capture, no response. The core must not issue a new request before ack/err.
- rdata holds its value until the next successful read. Writes leave rdata unchanged.
- Read-after-write to the same word: the read returns the merged new data, because the write completes in an earlier RESP.
- A write with partial we leaves the disabled lanes unchanged.
- addr[1:0] is ignored (word access) unless the optional feature is enabled.
- Reset asserted mid-transaction: the transaction is abandoned, no RAM write occurs if reset arrives before RESP, and no ack/err is produced.
- Address arithmetic is done in ADDR_WIDTH bits with no wrap. addr below BASE_ADDR gives err.

Optional Feature:
- Macro: JEDRO_1_DRAM_RESP_ALIGN_CHK_EN
- Defined: a request is treated as an error (err pulse, no RAM access, rdata unchanged) if either:
  - addr[1:0] != 0 and we is 4'b0000 or 4'b1111; or
  - we is not one of the legal patterns {0001, 0010, 0100, 1000, 0011, 1100, 1111, 0000}.
- Undefined: no alignment or pattern checks. addr[1:0] is ignored and any we pattern is accepted.

Test Plan:
- WAIT_STATES=0, BASE=0: write we=1111 addr=0x10 wdata=0xDEADBEEF, then read 0x10 → ack 2 cycles after each stb, read rdata=0xDEADBEEF, err never high.
- Partial write over 0xDEADBEEF at 0x10 with we=0100 wdata=0x00AA0000, then read → rdata=0xDEAABEEF.
- WAIT_STATES=3: read 0x10 → ack exactly 5 cycles after stb. A second stb issued 2 cycles after the first is ignored and produces exactly one ack.
- DEPTH_WORDS=1024: read 0x1000 → err pulse only, rdata unchanged. Write 0x1000 followed by a read of 0x0 shows word 0 unmodified.
- WAIT_STATES=3: write 0x20 0x12345678, deassert rstn_i while in WAIT → ack=err=0 immediately. After release, a read of 0x20 does not return 0x12345678 (word pre-cleared by an earlier write of 0).
- With JEDRO_1_DRAM_RESP_ALIGN_CHK_EN: we=1111 addr=0x11 → err. Without the macro, the same request → ack and a write to word 0x10.
